// File: rtl/vga_axil_slave_ctrl_if.sv
// AXI4-Lite slave-side channel bundle for the VGA register controller.
// Signal names keep the controller's _i/_o view; the master modport mirrors it.
interface vga_axil_slave_ctrl_if #(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32
);
  // AW channel
  logic [AXIL_ADDR_WIDTH-1:0]   awaddr_i;
  logic                         awvalid_i;
  logic                         awready_o;
  // W channel
  logic [AXIL_DATA_WIDTH-1:0]   wdata_i;
  logic [AXIL_DATA_WIDTH/8-1:0] wstrb_i;
  logic                         wvalid_i;
  logic                         wready_o;
  // B channel
  logic [1:0]                   bresp_o;
  logic                         bvalid_o;
  logic                         bready_i;
  // AR channel
  logic [AXIL_ADDR_WIDTH-1:0]   araddr_i;
  logic                         arvalid_i;
  logic                         arready_o;
  // R channel
  logic [AXIL_DATA_WIDTH-1:0]   rdata_o;
  logic [1:0]                   rresp_o;
  logic                         rvalid_o;
  logic                         rready_i;

  modport slave (
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o,
           rdata_o, rresp_o, rvalid_o
  );

  modport master (
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o,
           rdata_o, rresp_o, rvalid_o
  );
endinterface

// File: rtl/vga_axil_slave_ctrl.sv
// AXI4-Lite slave that turns single-beat reads/writes into native register-file
// strobes. One outstanding transaction per direction; misaligned or
// out-of-range word addresses answer SLVERR without touching the native side.
module vga_axil_slave_ctrl #(
  parameter  int AXIL_DATA_WIDTH   = 32,
  parameter  int AXIL_ADDR_WIDTH   = 32,
  parameter  int NUM_WORDS         = 16,
  parameter  int SINGLE_PORT       = 0,
  localparam int STRB_WIDTH        = AXIL_DATA_WIDTH / 8,
  localparam int OFFSET            = $clog2(STRB_WIDTH),
  localparam int NATIVE_ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  vga_axil_slave_ctrl_if.slave         axil,
  output logic                         write_en_o,
  output logic [NATIVE_ADDR_WIDTH-1:0] addr_write_o,
  output logic [AXIL_DATA_WIDTH-1:0]   data_o,
  output logic [STRB_WIDTH-1:0]        strb_o,
  output logic                         read_en_sync_o,
  output logic [NATIVE_ADDR_WIDTH-1:0] addr_read_o,
  input  logic [AXIL_DATA_WIDTH-1:0]   data_i
);

  typedef enum logic [2:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Misaligned byte lane or word index past the mapped range.
  function automatic logic addr_err(input logic [AXIL_ADDR_WIDTH-1:0] addr);
    logic [AXIL_ADDR_WIDTH-1:0] word_idx;
    word_idx = addr >> OFFSET;
    return (addr[OFFSET-1:0] != {OFFSET{1'b0}}) ||
           (word_idx >= AXIL_ADDR_WIDTH'(NUM_WORDS));
  endfunction

  function automatic logic [NATIVE_ADDR_WIDTH-1:0] native_addr(input logic [AXIL_ADDR_WIDTH-1:0] addr);
    return addr[OFFSET +: NATIVE_ADDR_WIDTH];
  endfunction

  w_state_t                     w_state_r, w_state_next_s;
  r_state_t                     r_state_r, r_state_next_s;
  logic [AXIL_ADDR_WIDTH-1:0]   aw_addr_r, ar_addr_r, aw_addr_s, rd_addr_s;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_r, wdata_s, data_r, rdata_r;
  logic [STRB_WIDTH-1:0]        wstrb_r, wstrb_s, strb_r;
  logic [NATIVE_ADDR_WIDTH-1:0] addr_write_r, addr_read_r;
  logic [1:0]                   bresp_r, rresp_r;
  logic awready_r, wready_r, arready_r, bvalid_r, rvalid_r, write_en_r, read_en_r;
  logic wr_err_r, rd_err_r;
  logic aw_hs_s, w_hs_s, ar_hs_s, wr_enter_exec_s, wr_fire_next_s, rd_fire_next_s;

  assign aw_hs_s = axil.awvalid_i && awready_r;
  assign w_hs_s  = axil.wvalid_i  && wready_r;
  assign ar_hs_s = axil.arvalid_i && arready_r;

  // Write next-state plus the operand view (this cycle's beat or the held one).
  always_comb begin
    w_state_next_s = w_state_r;
    aw_addr_s      = aw_hs_s ? axil.awaddr_i : aw_addr_r;
    wdata_s        = w_hs_s  ? axil.wdata_i  : wdata_r;
    wstrb_s        = w_hs_s  ? axil.wstrb_i  : wstrb_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s)  w_state_next_s = W_EXEC;
        else if (aw_hs_s)       w_state_next_s = W_HAVE_ADDR;
        else if (w_hs_s)        w_state_next_s = W_HAVE_DATA;
        else                    w_state_next_s = W_IDLE;
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) w_state_next_s = W_EXEC;
        else        w_state_next_s = W_HAVE_ADDR;
      end
      W_HAVE_DATA: begin
        if (aw_hs_s) w_state_next_s = W_EXEC;
        else         w_state_next_s = W_HAVE_DATA;
      end
      W_EXEC: w_state_next_s = W_RESP;
      W_RESP: begin
        if (axil.bready_i) w_state_next_s = W_IDLE;
        else               w_state_next_s = W_RESP;
      end
      default: w_state_next_s = W_IDLE;
    endcase
    wr_enter_exec_s = (w_state_r != W_EXEC) && (w_state_next_s == W_EXEC);
    wr_fire_next_s  = wr_enter_exec_s && !addr_err(aw_addr_s);
  end

  // Read next-state; a single-port write strobe pushes the read strobe out a cycle.
  always_comb begin
    r_state_next_s = r_state_r;
    rd_addr_s      = (r_state_r == R_IDLE) ? axil.araddr_i : ar_addr_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) r_state_next_s = R_EXEC;
        else         r_state_next_s = R_IDLE;
      end
      R_EXEC: begin
        if (read_en_r || rd_err_r) r_state_next_s = R_WAIT;
        else                       r_state_next_s = R_EXEC;
      end
      R_WAIT: r_state_next_s = R_RESP;
      R_RESP: begin
        if (axil.rready_i) r_state_next_s = R_IDLE;
        else               r_state_next_s = R_RESP;
      end
      default: r_state_next_s = R_IDLE;
    endcase
    rd_fire_next_s = (r_state_next_s == R_EXEC) && !addr_err(rd_addr_s) &&
                     !((SINGLE_PORT != 0) && wr_fire_next_s);
  end

  // Write state, captured beats and registered write-side outputs.
  always_ff @(posedge clk_i) begin
    if (!arst_n_i) begin
      w_state_r    <= W_IDLE;
      aw_addr_r    <= {AXIL_ADDR_WIDTH{1'b0}};
      wdata_r      <= {AXIL_DATA_WIDTH{1'b0}};
      wstrb_r      <= {STRB_WIDTH{1'b0}};
      awready_r    <= 1'b1;
      wready_r     <= 1'b1;
      write_en_r   <= 1'b0;
      wr_err_r     <= 1'b0;
      addr_write_r <= {NATIVE_ADDR_WIDTH{1'b0}};
      data_r       <= {AXIL_DATA_WIDTH{1'b0}};
      strb_r       <= {STRB_WIDTH{1'b0}};
      bresp_r      <= RESP_OKAY;
      bvalid_r     <= 1'b0;
    end else begin
      w_state_r  <= w_state_next_s;
      awready_r  <= (w_state_next_s == W_IDLE) || (w_state_next_s == W_HAVE_DATA);
      wready_r   <= (w_state_next_s == W_IDLE) || (w_state_next_s == W_HAVE_ADDR);
      write_en_r <= wr_fire_next_s;
      bvalid_r   <= (w_state_next_s == W_RESP);
      if (aw_hs_s) aw_addr_r <= axil.awaddr_i;
      if (w_hs_s) begin
        wdata_r <= axil.wdata_i;
        wstrb_r <= axil.wstrb_i;
      end
      if (wr_enter_exec_s) wr_err_r <= addr_err(aw_addr_s);
      if (wr_fire_next_s) begin
        addr_write_r <= native_addr(aw_addr_s);
        data_r       <= wdata_s;
        strb_r       <= wstrb_s;
      end
      if (w_state_r == W_EXEC) bresp_r <= wr_err_r ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read state, captured address and registered read-side outputs.
  always_ff @(posedge clk_i) begin
    if (!arst_n_i) begin
      r_state_r   <= R_IDLE;
      ar_addr_r   <= {AXIL_ADDR_WIDTH{1'b0}};
      rd_err_r    <= 1'b0;
      arready_r   <= 1'b1;
      read_en_r   <= 1'b0;
      addr_read_r <= {NATIVE_ADDR_WIDTH{1'b0}};
      rdata_r     <= {AXIL_DATA_WIDTH{1'b0}};
      rresp_r     <= RESP_OKAY;
      rvalid_r    <= 1'b0;
    end else begin
      r_state_r <= r_state_next_s;
      arready_r <= (r_state_next_s == R_IDLE);
      read_en_r <= rd_fire_next_s;
      rvalid_r  <= (r_state_next_s == R_RESP);
      if (ar_hs_s) begin
        ar_addr_r <= axil.araddr_i;
        rd_err_r  <= addr_err(axil.araddr_i);
      end
      if (rd_fire_next_s) addr_read_r <= native_addr(rd_addr_s);
      if (r_state_r == R_WAIT) begin
        rdata_r <= rd_err_r ? {AXIL_DATA_WIDTH{1'b0}} : data_i;
        rresp_r <= rd_err_r ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign axil.awready_o = awready_r;
  assign axil.wready_o  = wready_r;
  assign axil.bresp_o   = bresp_r;
  assign axil.bvalid_o  = bvalid_r;
  assign axil.arready_o = arready_r;
  assign axil.rdata_o   = rdata_r;
  assign axil.rresp_o   = rresp_r;
  assign axil.rvalid_o  = rvalid_r;
  assign write_en_o     = write_en_r;
  assign addr_write_o   = addr_write_r;
  assign data_o         = data_r;
  assign strb_o         = strb_r;
  assign read_en_sync_o = read_en_r;
  assign addr_read_o    = addr_read_r;

endmodule

// File: doc/vga_axil_slave_ctrl.md
VGA_AXIL_SLAVE_CTRL -- requirements
Module: vga_axil_slave_ctrl

Interface
REQ-001 The block SHALL have parameter AXIL_DATA_WIDTH, default 32, meaning data width in bits (32 or 64).
REQ-002 The block SHALL have parameter AXIL_ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 The block SHALL have parameter NUM_WORDS, default 16, meaning the number of native words mapped from byte address 0 (must be at least 1).
REQ-004 The block SHALL have parameter SINGLE_PORT, default 0, meaning native read and write share one port when 1.
REQ-005 Derived values SHALL be: OFFSET = log2(AXIL_DATA_WIDTH/8); NATIVE_ADDR_WIDTH = max(1, clog2(NUM_WORDS)).
REQ-006 clk_i  in  1  system clock; one clock domain only.
REQ-007 arst_n_i  in  1  reset; active-low and synchronous, sampled on the rising edge of clk_i only.
REQ-008 AW channel: awaddr_i in AXIL_ADDR_WIDTH; awvalid_i in 1; awready_o out 1.
REQ-009 W channel: wdata_i in AXIL_DATA_WIDTH; wstrb_i in AXIL_DATA_WIDTH/8; wvalid_i in 1; wready_o out 1.
REQ-010 B channel: bresp_o out 2; bvalid_o out 1; bready_i in 1.
REQ-011 AR channel: araddr_i in AXIL_ADDR_WIDTH; arvalid_i in 1; arready_o out 1.
REQ-012 R channel: rdata_o out AXIL_DATA_WIDTH; rresp_o out 2; rvalid_o out 1; rready_i in 1.
REQ-013 Native write port: write_en_o out 1; addr_write_o out NATIVE_ADDR_WIDTH; data_o out AXIL_DATA_WIDTH; strb_o out AXIL_DATA_WIDTH/8.
REQ-014 Native read port: read_en_sync_o out 1; addr_read_o out NATIVE_ADDR_WIDTH; data_i in AXIL_DATA_WIDTH, valid exactly one cycle after read_en_sync_o.

Function
REQ-015 Write FSM states SHALL be W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_EXEC, W_RESP.
REQ-016 In W_IDLE, awready_o and wready_o SHALL be 1; AW and W are captured independently in either order or in the same cycle.
REQ-017 The write FSM SHALL transition as follows: AW only -> W_HAVE_ADDR (awready_o=0); W only -> W_HAVE_DATA (wready_o=0); both -> W_EXEC.
REQ-018 In W_EXEC, write_en_o SHALL pulse for exactly 1 cycle for an OKAY address, then the FSM goes to W_RESP.
REQ-019 In W_RESP, bvalid_o SHALL be 1 and held, with bresp_o stable, until bready_i is 1; then the FSM returns to W_IDLE.
REQ-020 Write response latency SHALL be that bvalid_o asserts exactly 2 cycles after the cycle in which both AW and W have been captured.
REQ-021 Read FSM states SHALL be R_IDLE (arready_o=1), R_EXEC, R_WAIT, R_RESP.
REQ-022 The read FSM SHALL handle a read as follows: on AR handshake -> R_EXEC and pulse read_en_sync_o for 1 cycle; R_WAIT samples data_i into rdata_o; R_RESP holds rvalid_o until rready_i is 1.
REQ-023 Address decode SHALL be: native address = addr[OFFSET +: NATIVE_ADDR_WIDTH].
REQ-024 The response SHALL be SLVERR (2'b10) if addr[OFFSET-1:0] != 0 or word index >= NUM_WORDS; otherwise OKAY (2'b00).
REQ-025 On SLVERR, write_en_o and read_en_sync_o SHALL stay 0; rdata_o SHALL be 0 for a SLVERR read.
REQ-026 strb_o SHALL equal the captured wstrb_i; wstrb_i = 0 SHALL still pulse write_en_o and respond OKAY.
REQ-027 For SINGLE_PORT=0, the read and write FSMs SHALL be fully concurrent.
REQ-028 For SINGLE_PORT=1, a read strobe SHALL NOT fire in the same cycle as a write strobe.
REQ-029 For SINGLE_PORT=1 with both pending, the write SHALL have priority and the read SHALL remain in R_EXEC one extra cycle.
REQ-030 addr_write_o, data_o and strb_o SHALL hold their last values outside W_EXEC; addr_read_o SHALL hold its last value outside R_EXEC.
REQ-031 There SHALL be only one outstanding transaction per direction; a new AW/W/AR SHALL NOT be accepted until the previous response handshake completes.

Reset
REQ-032 While arst_n_i=0 at a clock edge, both FSMs SHALL enter their IDLE states.
REQ-033 Reset values SHALL be: awready_o=wready_o=arready_o=1 from the first cycle after reset release; bvalid_o=rvalid_o=0; write_en_o=read_en_sync_o=0.
REQ-034 The data and address outputs SHALL reset to 0 (bresp_o, rresp_o, rdata_o, addr_write_o, addr_read_o, data_o, strb_o).
REQ-035 Reset mid-transaction SHALL drop the transaction silently: no native strobe and no response after reset.

Verification
REQ-036 AW at cycle 0 and W at cycle 3 (addr 0x4, data 0xDEADBEEF, strb 0xF) -> write_en_o at cycle 4 with addr_write_o=1; bvalid_o at cycle 5 with OKAY.
REQ-037 W before AW, with bready_i held 0 for 5 cycles -> bvalid_o is held 5 cycles with bresp_o stable; no new AW is accepted until B completes.
REQ-038 Read 0x4 after the REQ-036 write, with data_i modelled one cycle after the strobe -> rdata_o=0xDEADBEEF, OKAY.
REQ-039 With NUM_WORDS=16, write 0x40 and read 0x2 -> SLVERR on both, no native strobe, rdata_o=0.
REQ-040 With SINGLE_PORT=1, AW, W and AR in the same cycle -> write_en_o fires first, read_en_sync_o fires one cycle later, both respond OKAY.
REQ-041 arst_n_i=0 during W_HAVE_ADDR and during R_WAIT -> all outputs take reset values, no bvalid_o/rvalid_o afterwards, and the next transaction completes normally.
